// File: rtl/conv3x3_window_gen_pkg.sv
// Shared defaults and derived constants for the 3x3 streaming window generator.
package conv3x3_window_gen_pkg;

  localparam int DEF_WI    = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  // Number of valid-padding 3x3 windows in a w x h image.
  function automatic int win_per_map(input int w, input int h);
    return (h - 2) * (w - 2);
  endfunction

  localparam int WIN_PER_MAP = win_per_map(DEF_IMG_W, DEF_IMG_H);
  localparam int COL_W       = $clog2(DEF_IMG_W);
  localparam int ROW_W       = $clog2(DEF_IMG_H);

endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay line: reads the old value at addr and overwrites it
// with din in the same accepted cycle. The read is combinational so the
// displaced pixel can join the window on the same edge as the incoming pixel.
module conv_line_buffer #(
  parameter int WI    = 8,
  parameter int DEPTH = 28,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [WI-1:0] din,
  output logic [WI-1:0] dout
);

  logic [WI-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // Replace the entry at addr once its old value has been read out.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 sliding-window generator: raster pixels in, packed 3x3
// valid-padding windows out, plus an end-of-frame strobe and frame counter.
module conv3x3_window_gen
  import conv3x3_window_gen_pkg::*;
#(
  parameter int WI    = DEF_WI,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iPixValid,
  input  logic [WI-1:0]   iPixData,
  output logic            oValid,
  output logic [3*WI-1:0] oWindowRow1,
  output logic [3*WI-1:0] oWindowRow2,
  output logic [3*WI-1:0] oWindowRow3,
  output logic            oMapDone,
  output logic [1:0]      oPass
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [1:0]    pass_reg;
  logic          valid_reg;
  logic          done_pend_reg;
  logic          done_reg;

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_ok;
  logic [WI-1:0] lb0_out;
  logic [WI-1:0] lb1_out;
  logic [WI-1:0] new_col [3];
  logic [3*WI-1:0] rows [3];

  // A pixel arriving together with reset is dropped.
  assign accept   = iPixValid & ~iRst;
  assign col_last = (col_reg == COL_LAST);
  assign row_last = (row_reg == ROW_LAST);
  assign win_ok   = (row_reg >= RW'(2)) && (col_reg >= CW'(2));

  // LB0 holds the previous row; whatever it displaces becomes the row before.
  conv_line_buffer #(
    .WI    (WI),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb0 (
    .clk  (iClk),
    .en   (accept),
    .addr (col_reg),
    .din  (iPixData),
    .dout (lb0_out)
  );

  conv_line_buffer #(
    .WI    (WI),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb1 (
    .clk  (iClk),
    .en   (accept),
    .addr (col_reg),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Incoming right-hand column: oldest row on top, live pixel at the bottom.
  assign new_col[0] = lb1_out;
  assign new_col[1] = lb0_out;
  assign new_col[2] = iPixData;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win_row
      logic [WI-1:0] taps_reg [3];

      // Shift this window row left by one column per accepted pixel.
      always_ff @(posedge iClk) begin
        if (iRst) begin
          taps_reg[0] <= '0;
          taps_reg[1] <= '0;
          taps_reg[2] <= '0;
        end else if (accept) begin
          taps_reg[0] <= taps_reg[1];
          taps_reg[1] <= taps_reg[2];
          taps_reg[2] <= new_col[gi];
        end
      end

      // Leftmost column lands in the MSBs.
      assign rows[gi] = {taps_reg[0], taps_reg[1], taps_reg[2]};
    end
  endgenerate

  // Raster position and completed-frame count advance only on accepted pixels.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      col_reg  <= '0;
      row_reg  <= '0;
      pass_reg <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        if (row_last) begin
          row_reg  <= '0;
          pass_reg <= pass_reg + 2'd1;
        end else begin
          row_reg <= row_reg + 1'b1;
        end
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Window valid follows its completing pixel by one cycle; the frame-done
  // strobe is staged one cycle further so it never overlaps the last window.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      valid_reg     <= 1'b0;
      done_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      valid_reg     <= accept & win_ok;
      done_pend_reg <= accept & col_last & row_last;
      done_reg      <= done_pend_reg;
    end
  end

  assign oValid      = valid_reg;
  assign oWindowRow1 = rows[0];
  assign oWindowRow2 = rows[1];
  assign oWindowRow3 = rows[2];
  assign oMapDone    = done_reg;
  assign oPass       = pass_reg;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen: three instances (4x4, 3x3, 28x28) share the
// stimulus; a frame-array model predicts every cycle of the selected instance.
module tb_conv3x3_window_gen;

  logic       clk;
  logic       rst;
  logic       pix_valid;
  logic [7:0] pix_data;

  logic        v4, v3, v28, d4, d3, d28;
  logic [1:0]  p4, p3, p28;
  logic [23:0] a4, b4, c4, a3, b3, c3, a28, b28, c28;

  conv3x3_window_gen #(.WI(8), .IMG_W(4), .IMG_H(4)) u_d4 (
    .iClk(clk), .iRst(rst), .iPixValid(pix_valid), .iPixData(pix_data),
    .oValid(v4), .oWindowRow1(a4), .oWindowRow2(b4), .oWindowRow3(c4),
    .oMapDone(d4), .oPass(p4));

  conv3x3_window_gen #(.WI(8), .IMG_W(3), .IMG_H(3)) u_d3 (
    .iClk(clk), .iRst(rst), .iPixValid(pix_valid), .iPixData(pix_data),
    .oValid(v3), .oWindowRow1(a3), .oWindowRow2(b3), .oWindowRow3(c3),
    .oMapDone(d3), .oPass(p3));

  conv3x3_window_gen #(.WI(8), .IMG_W(28), .IMG_H(28)) u_d28 (
    .iClk(clk), .iRst(rst), .iPixValid(pix_valid), .iPixData(pix_data),
    .oValid(v28), .oWindowRow1(a28), .oWindowRow2(b28), .oWindowRow3(c28),
    .oMapDone(d28), .oPass(p28));

  int sel;
  int img_w, img_h;
  logic        obs_valid, obs_done;
  logic [1:0]  obs_pass;
  logic [23:0] obs_r1, obs_r2, obs_r3;

  always_comb begin
    obs_valid = v4; obs_done = d4; obs_pass = p4;
    obs_r1 = a4; obs_r2 = b4; obs_r3 = c4;
    if (sel == 1) begin
      obs_valid = v3; obs_done = d3; obs_pass = p3;
      obs_r1 = a3; obs_r2 = b3; obs_r3 = c3;
    end else if (sel == 2) begin
      obs_valid = v28; obs_done = d28; obs_pass = p28;
      obs_r1 = a28; obs_r2 = b28; obs_r3 = c28;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: the frame image plus raster position.
  logic [7:0] frame [0:27][0:27];
  int m_r, m_c, m_pass;
  bit pend;
  int n_checks, n_pass;
  int win_seen, done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] win_row(input int r, input int c);
    return {frame[r][c-2], frame[r][c-1], frame[r][c]};
  endfunction

  // One clock: drive inputs, predict the registered outputs, check them.
  task automatic tick(input logic r_in, input logic v, input logic [7:0] d);
    logic e_valid, e_done;
    logic [23:0] e1, e2, e3;
    e_valid = 1'b0; e_done = 1'b0; e1 = '0; e2 = '0; e3 = '0;
    rst = r_in; pix_valid = v; pix_data = d;
    if (r_in) begin
      m_r = 0; m_c = 0; m_pass = 0; pend = 0;
    end else begin
      e_done = pend;
      pend = 0;
      if (v) begin
        frame[m_r][m_c] = d;
        if (m_r >= 2 && m_c >= 2) begin
          e_valid = 1'b1;
          e1 = win_row(m_r - 2, m_c);
          e2 = win_row(m_r - 1, m_c);
          e3 = win_row(m_r, m_c);
        end
        if (m_c == img_w - 1) begin
          m_c = 0;
          if (m_r == img_h - 1) begin
            m_r = 0; m_pass = (m_pass + 1) % 4; pend = 1;
          end else m_r++;
        end else m_c++;
      end
    end
    @(negedge clk);
    check("valid", 32'(obs_valid), 32'(e_valid));
    check("map_done", 32'(obs_done), 32'(e_done));
    check("pass", 32'(obs_pass), 32'(m_pass));
    if (r_in || e_valid) begin
      check("row1", 32'(obs_r1), 32'(e1));
      check("row2", 32'(obs_r2), 32'(e2));
      check("row3", 32'(obs_r3), 32'(e3));
    end
    if (obs_valid) win_seen++;
    if (obs_done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'($urandom));
  endtask

  // mode 0: ramp r*W+c, mode 1: random signed pixels.
  task automatic feed(input int mode, input int gap_pct, input int npix);
    logic [7:0] px;
    for (int i = 0; i < npix; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick(1'b0, 1'b0, 8'($urandom));
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick(1'b0, 1'b0, 8'($urandom));
      px = (mode == 0) ? 8'(i) : 8'($urandom);
      tick(1'b0, 1'b1, px);
    end
  endtask

  task automatic start(input int s, input int w, input int h);
    sel = s; img_w = w; img_h = h;
    tick(1'b1, 1'b1, 8'($urandom));
    tick(1'b1, 1'b0, 8'h00);
    win_seen = 0; done_seen = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0;
    m_r = 0; m_c = 0; m_pass = 0; pend = 0;

    // 4x4 ramp frame, back to back.
    start(0, 4, 4);
    feed(0, 0, 16);
    idle(3);
    check("win_count_4x4", 32'(win_seen), 32'd4);
    check("done_count_4x4", 32'(done_seen), 32'd1);

    // Same frame with random idle cycles.
    win_seen = 0; done_seen = 0;
    feed(0, 40, 16);
    idle(3);
    check("win_count_gaps", 32'(win_seen), 32'd4);
    check("done_count_gaps", 32'(done_seen), 32'd1);

    // Four consecutive frames: pass wraps, four done pulses.
    start(0, 4, 4);
    feed(0, 0, 64);
    idle(3);
    check("win_count_4frames", 32'(win_seen), 32'd16);
    check("done_count_4frames", 32'(done_seen), 32'd4);

    // Reset after pixel 9, then a full fresh frame.
    start(0, 4, 4);
    feed(0, 0, 10);
    tick(1'b1, 1'b1, 8'($urandom));
    win_seen = 0; done_seen = 0;
    feed(0, 0, 16);
    idle(3);
    check("win_count_after_rst", 32'(win_seen), 32'd4);
    check("done_count_after_rst", 32'(done_seen), 32'd1);

    // Reset right after a frame's last pixel cancels the pending done.
    start(0, 4, 4);
    feed(1, 0, 16);
    tick(1'b1, 1'b0, 8'h00);
    win_seen = 0; done_seen = 0;
    idle(3);
    check("done_cancelled", 32'(done_seen), 32'd0);

    // Minimum 3x3 image: one window then done.
    start(1, 3, 3);
    feed(0, 0, 9);
    idle(3);
    check("win_count_3x3", 32'(win_seen), 32'd1);
    check("done_count_3x3", 32'(done_seen), 32'd1);

    // Default 28x28 random signed frame.
    start(2, 28, 28);
    feed(1, 5, 784);
    idle(3);
    check("win_count_28x28", 32'(win_seen), 32'd676);
    check("done_count_28x28", 32'(done_seen), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
